// File: rtl/dec_pkg.sv
// dec_pkg: shared FSM states, core operation codes and GF(2^8) helper
// for the decrypt round scheduler and its core.
package dec_pkg;
    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_ROUND, S_TAIL, S_DONE} state_t;
    typedef enum logic [1:0] {M_NONE = 2'd0, M_HEAD = 2'd1, M_ROUND = 2'd2, M_TAIL = 2'd3} mode_t;

    localparam int         NUM_ROUNDS = 9;
    localparam logic [3:0] KEY_FIRST  = 4'd11;
    localparam logic [3:0] KEY_LAST   = 4'd1;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
endpackage

// File: rtl/dec_core_mux.sv
// dec_core_mux: combinational AES-style decrypt core; core_mode picks the
// HEAD, ROUND or TAIL step, i_sel=1 bypasses the inverse row shift.
module dec_core_mux
    import dec_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_key,
    input  logic [1:0]   i_mode,
    input  logic         i_sel,
    output logic [127:0] o_result
);
    logic [127:0] w_ark, w_pre, w_isr, w_sub;

    // inverse affine map, then multiplicative inverse as x^254
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] p, r;
        p = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] nov_inv_shiftrow(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
        return o;
    endfunction

    // HEAD and ROUND share the shift/substitute tail; ROUND adds the column mix
    assign w_ark    = i_state ^ i_key;
    assign w_pre    = (i_mode == M_ROUND) ? inv_mix(w_ark) : w_ark;
    assign w_isr    = i_sel ? w_pre : nov_inv_shiftrow(w_pre);
    assign w_sub    = sub_bytes(w_isr);
    assign o_result = (i_mode == M_TAIL) ? w_ark : (i_mode == M_NONE) ? i_state : w_sub;
endmodule

// File: rtl/decrypt_round_sched.sv
// decrypt_round_sched: sequences HEAD, 9 ROUNDs and TAIL on a shared external
// core, holding each step ROUND_LAT cycles, then presents the plaintext.
module decrypt_round_sched
    import dec_pkg::*;
#(
    parameter int ROUND_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_an,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cipher,
    input  logic         select_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plain,
    output logic [3:0]   key_idx,
    output logic [1:0]   core_mode,
    output logic         core_sel,
    output logic [127:0] core_in,
    input  logic [127:0] core_out,
    output logic         busy
);
    state_t       r_state, w_next;
    mode_t        w_mode;
    logic [127:0] r_data;
    logic         r_sel;
    logic [3:0]   r_round, w_key;
    logic [1:0]   r_wait;
    logic         w_last;

    assign w_last = (r_wait == 2'(ROUND_LAT - 1));

    always_ff @(posedge clk or negedge rst_an)
        if (!rst_an) r_state <= S_IDLE;
        else         r_state <= w_next;

    always_comb begin
        w_next = r_state;
        w_key  = 4'd0;
        w_mode = M_NONE;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_HEAD;
            S_HEAD: begin
                w_key  = KEY_FIRST;
                w_mode = M_HEAD;
                if (w_last) w_next = S_ROUND;
            end
            S_ROUND: begin
                w_key  = KEY_FIRST - 4'd1 - r_round;
                w_mode = M_ROUND;
                if (w_last && r_round == 4'(NUM_ROUNDS - 1)) w_next = S_TAIL;
            end
            S_TAIL: begin
                w_key  = KEY_LAST;
                w_mode = M_TAIL;
                if (w_last) w_next = S_DONE;
            end
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_an)
        if (!rst_an) begin
            r_data  <= '0;
            r_sel   <= 1'b0;
            r_round <= 4'd0;
            r_wait  <= 2'd0;
        end else if (r_state == S_IDLE) begin
            if (in_valid) begin
                r_data  <= cipher;
                r_sel   <= select_in;
                r_round <= 4'd0;
                r_wait  <= 2'd0;
            end
        end else if (w_mode != M_NONE) begin
            r_wait <= w_last ? 2'd0 : r_wait + 2'd1;
            if (w_last) begin
                r_data <= core_out;
                if (r_state == S_ROUND) r_round <= r_round + 4'd1;
            end
        end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = !in_ready;
    assign out_valid = (r_state == S_DONE);
    assign plain     = r_data;
    assign core_in   = r_data;
    assign core_sel  = r_sel;
    assign key_idx   = w_key;
    assign core_mode = w_mode;
endmodule

// File: doc/decrypt_round_sched.md
DECRYPT_ROUND_SCHED -- requirements
Module: decrypt_round_sched

Interface
REQ-001 Parameter ROUND_LAT, default 1, SHALL be the core latency in cycles (core_in/core_mode/key_idx to valid core_out), legal range 1..4.
REQ-002 clk  input  1  SHALL be the single rising-edge clock.
REQ-003 rst_an  input  1  SHALL be the asynchronous active-low reset.
REQ-004 in_valid  input  1  SHALL flag that cipher/select_in are offered.
REQ-005 in_ready  output  1  SHALL flag that the block accepts a block this cycle.
REQ-006 cipher  input  128  SHALL be the ciphertext block.
REQ-007 select_in  input  1  SHALL be the datapath variant select, forwarded to the core.
REQ-008 out_valid  output  1  SHALL flag that plain holds a finished block.
REQ-009 out_ready  input  1  SHALL flag that the consumer takes plain.
REQ-010 plain  output  128  SHALL be the recovered plaintext.
REQ-011 key_idx  output  4  SHALL select the round key (1..11) from the external key bank.
REQ-012 core_mode  output  2  SHALL select the core operation: 0 none, 1 HEAD (addroundkey, inverse shift rows, subBytes), 2 ROUND (one decrypt round), 3 TAIL (addroundkey only).
REQ-013 core_sel  output  1  SHALL be the latched select for the core.
REQ-014 core_in  output  128  SHALL be the state register, driven to the shared core.
REQ-015 core_out  input  128  SHALL be the core result.
REQ-016 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, HEAD, ROUND, TAIL, DONE.
REQ-018 in_ready SHALL equal (state==IDLE); acceptance SHALL be in_valid && in_ready at a rising edge.
REQ-019 On acceptance: state register <= cipher, core_sel <= select_in, round counter <= 0, wait counter <= 0, state -> HEAD.
REQ-020 Each of HEAD, ROUND, TAIL SHALL hold key_idx/core_mode stable for exactly ROUND_LAT cycles, then capture core_out into the state register on the ROUND_LAT-th edge.
REQ-021 key_idx SHALL be 11 in HEAD, 10-r in ROUND iteration r (r = 0..8), 1 in TAIL, 0 in IDLE/DONE.
REQ-022 ROUND SHALL run exactly 9 iterations, then go to TAIL; TAIL capture SHALL go to DONE.
REQ-023 out_valid SHALL rise after edge E0+11*ROUND_LAT (E0 = accepting edge) and plain SHALL equal the state register.
REQ-024 In DONE, out_valid and plain SHALL stay stable until out_valid && out_ready, then state -> IDLE; no acceptance in DONE.
REQ-025 cipher, select_in and in_valid changes while busy SHALL be ignored.
REQ-026 core_mode SHALL be 0 in IDLE and DONE.

Reset
REQ-027 rst_an low SHALL immediately force IDLE, state register 0, counters 0, key_idx 0, core_mode 0, core_sel 0, out_valid 0, busy 0, in_ready 1, aborting any block in flight with no output.

Structure
REQ-028 Package dec_pkg SHALL hold the FSM state enum, core_mode encodings, NUM_ROUNDS=9, KEY_FIRST=11, KEY_LAST=1.
REQ-029 One sub-module dec_core_mux SHALL wrap addroundkey, nov_inv_shiftrow, subBytes and decrypt_round behind core_mode.

Verification
REQ-030 ROUND_LAT=1, cipher 128'h68a4b9aebdcf11fcf5dd6653952cbc46, select 0 -> key_idx 11,10..2,1 one per cycle, core_mode 1, 2 (x9), 3, out_valid 11 cycles after accept, plain equals the unrolled decrypt model.
REQ-031 out_ready low 5 cycles in DONE -> out_valid, plain stable; in_ready 0; IDLE one cycle after handshake.
REQ-032 ROUND_LAT=3 -> each key_idx held 3 cycles, out_valid 33 cycles after accept, plain matches model.
REQ-033 rst_an pulsed during ROUND r=5 -> out_valid 0, key_idx 0, in_ready 1 at once; next block after release decrypts correctly.
REQ-034 cipher/select_in toggled and in_valid held high while busy -> no second acceptance; result matches first block.
REQ-035 Two blocks back-to-back, out_ready tied 1 -> second accepted one cycle after first output handshake; both plains match model.
